// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button front-end.
package button_pkg;

  // Per-channel debounce state. The debounced level is 1 in PRESSED and
  // RELEASE_WAIT, and 0 in RELEASED and PRESS_WAIT.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Bits needed to hold values 0..n (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with agreement
// counter, registered press/release pulses and hold-to-repeat timer.
// Input p is already polarity-normalised (1 = pressed).
// Pulse outputs are single-cycle and registered; there is no handshake,
// a pulse is valid for exactly the one cycle it is high.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       p,
  input  logic       repeat_en,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output btn_state_e state
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  // Counter value whose increment would reach the target.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic          s1, s2;
  btn_state_e    state_next;
  logic [DW-1:0] deb_cnt, deb_next;
  logic          deb_done;
  logic          level_next, press_next, release_next;
  logic [HW-1:0] hold_cnt, hold_next, hold_target;
  logic          first_rep, first_next;
  logic          repeat_next;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= p;
      s2 <= s1;
    end
  end

  assign deb_done = (deb_cnt == DEB_LAST);

  // Debounce FSM next state: count consecutive disagreeing samples,
  // clear on any agreeing sample, commit the new level on completion.
  always_comb begin
    state_next   = state;
    deb_next     = '0;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      RELEASED: begin
        if (s2) begin
          if (deb_done) begin
            state_next = PRESSED;
            press_next = 1'b1;
          end else begin
            state_next = PRESS_WAIT;
            deb_next   = deb_cnt + DW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_next = RELEASED;
        end else if (deb_done) begin
          state_next = PRESSED;
          press_next = 1'b1;
        end else begin
          deb_next = deb_cnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          if (deb_done) begin
            state_next   = RELEASED;
            release_next = 1'b1;
          end else begin
            state_next = RELEASE_WAIT;
            deb_next   = deb_cnt + DW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_next = PRESSED;
        end else if (deb_done) begin
          state_next   = RELEASED;
          release_next = 1'b1;
        end else begin
          deb_next = deb_cnt + DW'(1);
        end
      end
      default: state_next = RELEASED;
    endcase
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

  // FSM, debounce counter and level/edge pulse registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      deb_cnt       <= deb_next;
      level         <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  // Hold timer: runs only while pressed and enabled. The first interval
  // is HOLD_CYCLES, later ones REPEAT_CYCLES. Any gap (mask low or level
  // low) re-arms the long first interval. The edge that drops the level
  // clears the timer without firing, so repeat never meets release.
  always_comb begin
    hold_next   = '0;
    first_next  = 1'b1;
    repeat_next = 1'b0;
    hold_target = first_rep ? HOLD_LAST : REP_LAST;
    if (level && repeat_en && !release_next) begin
      if (hold_cnt == hold_target) begin
        repeat_next = 1'b1;
        first_next  = 1'b0;
      end else begin
        hold_next  = hold_cnt + HW'(1);
        first_next = first_rep;
      end
    end
  end

  // Hold timer and repeat pulse registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_cnt     <= '0;
      first_rep    <= 1'b1;
      repeat_pulse <= 1'b0;
    end else begin
      hold_cnt     <= hold_next;
      first_rep    <= first_next;
      repeat_pulse <= repeat_next;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: normalises polarity and runs an
// independent debounce/auto-repeat channel per button.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_BTN-1:0]     btn_raw,
  input  logic [NUM_BTN-1:0]     repeat_mask,
  output logic [NUM_BTN-1:0]     btn_level,
  output logic [NUM_BTN-1:0]     btn_press,
  output logic [NUM_BTN-1:0]     btn_release,
  output logic [NUM_BTN-1:0]     btn_repeat,
  output logic [2*NUM_BTN-1:0]   state_dbg
);

  // Parameter legality, rejected at elaboration.
  if (NUM_BTN < 1) begin : g_bad_num
    $error("button_conditioner: NUM_BTN must be >= 1");
  end
  if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_pol
    $error("button_conditioner: ACTIVE_LOW must be 0 or 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_conditioner: HOLD_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("button_conditioner: REPEAT_CYCLES must be >= 1");
  end

  localparam logic [NUM_BTN-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_BTN-1:0] p;

  // After this XOR a 1 always means pressed.
  assign p = btn_raw ^ POL_MASK;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_state_e ch_state;

    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .Clk           (Clk),
      .Reset         (Reset),
      .p             (p[i]),
      .repeat_en     (repeat_mask[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i]),
      .repeat_pulse  (btn_repeat[i]),
      .state         (ch_state)
    );

    assign state_dbg[2*i +: 2] = ch_state;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (D=4, H=8, R=3, active-low, 2 ch).
// The driver pushes expected pulse events {edge, press, release, repeat}
// and a monitor pops/compares whenever any pulse output is high.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int EW = 16 + 3 * NB;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] repeat_mask;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic [2*NB-1:0] state_dbg;

  button_conditioner #(
    .NUM_BTN         (NB),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8),
    .REPEAT_CYCLES   (3)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .btn_raw     (btn_raw),
    .repeat_mask (repeat_mask),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset / edge counter ----------------
  always #5 Clk = ~Clk;

  int cyc  = 0;
  int base = 0;
  always @(posedge Clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // Step to just after the next falling edge (clear of the monitor sample).
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      #2;
    end
  endtask

  // Mark the next rising edge as edge 0 of a scenario.
  task automatic mark_edge0();
    base = cyc;
  endtask

  task automatic push_exp(input int e, input logic [NB-1:0] pr,
                          input logic [NB-1:0] rl, input logic [NB-1:0] rp);
    exp_q.push_back({16'(e), pr, rl, rp});
  endtask

  task automatic check_level(input logic [NB-1:0] want, input string name);
    n_tests++;
    if (btn_level !== want) begin
      n_fail++;
      $display("FAIL %s: btn_level got %b want %b", name, btn_level, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [4*NB-1:0] got;
    got = {btn_level, btn_press, btn_release, btn_repeat};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs got %b want all 0", name, got);
    end
  endtask

  task automatic check_empty(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected pulse events never seen, want 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    logic [EW-1:0] got, exp;
    if ((btn_press | btn_release | btn_repeat) !== '0) begin
      got = {16'(cyc - base - 1), btn_press, btn_release, btn_repeat};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got edge=%0d prs/rel/rpt=%b want none",
                 got[EW-1 -: 16], got[3*NB-1:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL pulse_event: got edge=%0d prs/rel/rpt=%b want edge=%0d prs/rel/rpt=%b",
                   got[EW-1 -: 16], got[3*NB-1:0], exp[EW-1 -: 16], exp[3*NB-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset       = 1'b1;
    btn_raw     = 2'b11;
    repeat_mask = 2'b00;
    tick(3);
    check_all_zero("reset_state");
    Reset = 1'b0;
    tick(6);
    check_all_zero("idle_after_reset");

    // Clean press on channel 0, no repeat enabled.
    push_exp(5, 2'b01, 2'b00, 2'b00);
    btn_raw = 2'b10; mark_edge0();
    tick(5); check_level(2'b00, "press_edge4_level");
    tick(1); check_level(2'b01, "press_edge5_level");
    tick(10);
    push_exp(5, 2'b00, 2'b01, 2'b00);
    btn_raw = 2'b11; mark_edge0();
    tick(5); check_level(2'b01, "release_edge4_level");
    tick(1); check_level(2'b00, "release_edge5_level");
    tick(5); check_empty("clean_press");
    tick($urandom_range(2, 6));

    // Bounce: 3 cycles pressed then released, must be ignored.
    btn_raw = 2'b10; mark_edge0();
    tick(3); btn_raw = 2'b11;
    tick(2); check_level(2'b00, "bounce_level_mid");
    tick(15); check_level(2'b00, "bounce_level_end");
    check_empty("bounce");
    tick($urandom_range(2, 6));

    // Auto-repeat on channel 0; release timed so a repeat would land on
    // the release edge (28) and must be suppressed there.
    repeat_mask = 2'b01;
    push_exp(5,  2'b01, 2'b00, 2'b00);
    push_exp(13, 2'b00, 2'b00, 2'b01);
    push_exp(16, 2'b00, 2'b00, 2'b01);
    push_exp(19, 2'b00, 2'b00, 2'b01);
    push_exp(22, 2'b00, 2'b00, 2'b01);
    push_exp(25, 2'b00, 2'b00, 2'b01);
    push_exp(28, 2'b00, 2'b01, 2'b00);
    btn_raw = 2'b10; mark_edge0();
    tick(23); btn_raw = 2'b11;
    tick(10); check_level(2'b00, "autorep_level_end");
    check_empty("auto_repeat");
    repeat_mask = 2'b00;
    tick($urandom_range(2, 6));

    // Mask drop before edge 17: only repeats 13 and 16.
    repeat_mask = 2'b01;
    push_exp(5,  2'b01, 2'b00, 2'b00);
    push_exp(13, 2'b00, 2'b00, 2'b01);
    push_exp(16, 2'b00, 2'b00, 2'b01);
    push_exp(30, 2'b00, 2'b01, 2'b00);
    btn_raw = 2'b10; mark_edge0();
    tick(17); repeat_mask = 2'b00;
    tick(8);  btn_raw = 2'b11;
    tick(10); check_empty("mask_drop");
    tick($urandom_range(2, 6));

    // Both channels together; channel 1 repeats, its repeat at the
    // release edge (19) is suppressed.
    repeat_mask = 2'b10;
    push_exp(5,  2'b11, 2'b00, 2'b00);
    push_exp(13, 2'b00, 2'b00, 2'b10);
    push_exp(16, 2'b00, 2'b00, 2'b10);
    push_exp(19, 2'b00, 2'b11, 2'b00);
    btn_raw = 2'b00; mark_edge0();
    tick(6); check_level(2'b11, "simul_level_pressed");
    tick(8); btn_raw = 2'b11;
    tick(10); check_level(2'b00, "simul_level_released");
    check_empty("simultaneous");
    repeat_mask = 2'b00;
    tick($urandom_range(2, 6));

    // Reset mid-hold with the button kept pressed: everything clears at
    // once, then a fresh press appears 6 edges after deassertion.
    repeat_mask = 2'b01;
    push_exp(5, 2'b01, 2'b00, 2'b00);
    btn_raw = 2'b10; mark_edge0();
    tick(11); check_level(2'b01, "pre_reset_level");
    Reset = 1'b1;
    #1 check_all_zero("async_reset_clear");
    tick(1);
    Reset = 1'b0; mark_edge0();
    push_exp(5, 2'b01, 2'b00, 2'b00);
    tick(5); check_level(2'b00, "post_reset_edge4_level");
    tick(1); check_level(2'b01, "post_reset_edge5_level");
    repeat_mask = 2'b00;
    tick(2);
    push_exp(5, 2'b00, 2'b01, 2'b00);
    btn_raw = 2'b11; mark_edge0();
    tick(10); check_empty("reset_mid_op");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
